bin_to_bcd_converter: RTL and testbench

//  Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble).

---
 rtl/bin_to_bcd_if.sv | 24 ++
 rtl/bin_to_bcd_converter.sv | 122 ++++++++++++
 tb/tb_bin_to_bcd_converter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_if.sv
// Handshake and result bundle for the binary-to-BCD converter.
// master drives start/bin_in; slave returns busy/done/bcd_out/blank/overflow.
interface bin_to_bcd_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]     blank;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, blank, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, blank, overflow
    );
endinterface

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with leading-zero mask.
// Ports: clk, rst_n (async low), bus (slave: start/bin_in in; busy/done/bcd_out/blank/overflow out).
module bin_to_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    bin_to_bcd_if.slave   bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [BW-1:0]     scratch_q, scratch_d;
    logic              ovf_s_q, ovf_s_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              ovf_q, ovf_d;

    logic [BW-1:0]     adj;
    logic [BW-1:0]     nxt_scratch;
    logic              nxt_ovf;
    logic [DIGITS-1:0] nxt_blank;
    logic              lead;

    // One double-dabble step: add-3 fixup, then shift; the bit that falls
    // off the top digit means the value needs more digits than we have.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4]
                          + ((scratch_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
        end
        nxt_scratch = {adj[BW-2:0], shreg_q[WIDTH-1]};
        nxt_ovf     = ovf_s_q | adj[BW-1];
    end

    // Digit i is blanked only if it and every digit above it are zero.
    always_comb begin
        nxt_blank = '0;
        lead      = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead         = lead & (nxt_scratch[4*i +: 4] == 4'd0);
            nxt_blank[i] = lead;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        ovf_s_d   = ovf_s_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    shreg_d   = bus.bin_in;
                    scratch_d = '0;
                    ovf_s_d   = 1'b0;
                    cnt_d     = CW'(WIDTH);
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
                scratch_d = nxt_scratch;
                ovf_s_d   = nxt_ovf;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    bcd_d   = nxt_scratch;
                    blank_d = nxt_blank;
                    ovf_d   = nxt_ovf;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            ovf_s_q   <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            blank_q   <= BLANK_RST;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            ovf_s_q   <= ovf_s_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy     = (state_q == S_SHIFT);
    assign bus.done     = (state_q == S_DONE);
    assign bus.bcd_out  = bcd_q;
    assign bus.blank    = blank_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed-vector bench for bin_to_bcd_converter (5-digit and 4-digit builds).
// Ports exercised: clk, rst_n, and both interface bundles.
module tb_bin_to_bcd_converter;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bin_to_bcd_if #(.WIDTH(16), .DIGITS(5)) ifa ();
    bin_to_bcd_if #(.WIDTH(16), .DIGITS(4)) ifb ();

    bin_to_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    bin_to_bcd_converter #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Counts edges after the accept edge until done is seen; 40 = timed out.
    task automatic wait_done(input bit b4, output int n);
        n = 40;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (b4 ? ifb.done : ifa.done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic conv5(input logic [15:0] v, output int n);
        ifa.bin_in = v;
        ifa.start  = 1'b1;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        wait_done(1'b0, n);
    endtask

    task automatic conv4(input logic [15:0] v, output int n);
        ifb.bin_in = v;
        ifb.start  = 1'b1;
        @(posedge clk);
        #1;
        ifb.start = 1'b0;
        wait_done(1'b1, n);
    endtask

    typedef struct {
        logic [15:0] v;
        logic [19:0] bcd;
        logic [4:0]  blk;
    } vec_t;

    vec_t vecs[5] = '{
        '{16'd65535, 20'h65535, 5'b00000},
        '{16'd1234,  20'h01234, 5'b10000},
        '{16'd9,     20'h00009, 5'b11110},
        '{16'd10,    20'h00010, 5'b11100},
        '{16'd500,   20'h00500, 5'b11000}
    };

    initial begin
        int n;
        int nbusy;
        int ndone;
        logic [19:0] seen;

        rst_n      = 1'b0;
        ifa.start  = 1'b0;
        ifa.bin_in = '0;
        ifb.start  = 1'b0;
        ifb.bin_in = '0;
        #12;
        chk("rst_busy",  ifa.busy, 0);
        chk("rst_done",  ifa.done, 0);
        chk("rst_bcd",   ifa.bcd_out, 0);
        chk("rst_blank", ifa.blank, 5'b11110);
        chk("rst_ovf",   ifa.overflow, 0);
        chk("rst_blank4", ifb.blank, 4'b1110);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        conv5(16'd0, n);
        chk("zero_lat",   n + 1, 17);
        chk("zero_bcd",   ifa.bcd_out, 20'h00000);
        chk("zero_blank", ifa.blank, 5'b11110);
        chk("zero_ovf",   ifa.overflow, 0);

        foreach (vecs[k]) begin
            conv5(vecs[k].v, n);
            chk($sformatf("v%0d_lat", k), n + 1, 17);
            chk($sformatf("v%0d_bcd", k), ifa.bcd_out, vecs[k].bcd);
            chk($sformatf("v%0d_blank", k), ifa.blank, vecs[k].blk);
            chk($sformatf("v%0d_ovf", k), ifa.overflow, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("hold_bcd",  ifa.bcd_out, 20'h00500);
        chk("hold_done", ifa.done, 0);

        // start held high through SHIFT with bin_in wandering
        ifa.bin_in = 16'd777;
        ifa.start  = 1'b1;
        @(posedge clk);
        #1;
        nbusy = 0;
        ndone = 0;
        seen  = '0;
        for (int c = 0; c < 30; c++) begin
            if (c == 15) ifa.start = 1'b0;
            else if (c < 15) ifa.bin_in = 16'(1000 + c * 37);
            if (ifa.busy) nbusy++;
            if (ifa.done) begin
                ndone++;
                seen = ifa.bcd_out;
            end
            @(posedge clk);
            #1;
        end
        chk("hold_start_busy", nbusy, 16);
        chk("hold_start_done", ndone, 1);
        chk("hold_start_bcd",  seen, 20'h00777);

        // back-to-back restart from the DONE cycle
        conv5(16'd5, n);
        chk("b2b_first", ifa.bcd_out, 20'h00005);
        ifa.bin_in = 16'd42;
        ifa.start  = 1'b1;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        chk("b2b_busy", ifa.busy, 1);
        wait_done(1'b0, n);
        chk("b2b_lat",   n + 1, 17);
        chk("b2b_bcd",   ifa.bcd_out, 20'h00042);
        chk("b2b_blank", ifa.blank, 5'b11100);

        // asynchronous reset in the middle of SHIFT
        ifa.bin_in = 16'd65535;
        ifa.start  = 1'b1;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  ifa.busy, 0);
        chk("mid_rst_bcd",   ifa.bcd_out, 0);
        chk("mid_rst_blank", ifa.blank, 5'b11110);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (ifa.done) ndone++;
        end
        chk("mid_rst_nodone", ndone, 0);

        // four-digit build: truncation and overflow recovery
        conv4(16'd12345, n);
        chk("d4_lat",   n + 1, 17);
        chk("d4_bcd",   ifb.bcd_out, 16'h2345);
        chk("d4_ovf",   ifb.overflow, 1);
        chk("d4_blank", ifb.blank, 4'b0000);
        conv4(16'd9999, n);
        chk("d4_fit_bcd", ifb.bcd_out, 16'h9999);
        chk("d4_fit_ovf", ifb.overflow, 0);
        conv4(16'd7, n);
        chk("d4_small_bcd",   ifb.bcd_out, 16'h0007);
        chk("d4_small_blank", ifb.blank, 4'b1110);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
